// File: rtl/nice_chain_arbiter.sv
// Priority/round-robin request merger with per-channel lock and
// in-order response routing back to the originating channel.
module nice_chain_arbiter #(
    parameter int NUM_CH          = 4,
    parameter int DATA_W          = 32,
    parameter int PRIO_W          = 2,
    parameter int MAX_OUTSTANDING = 8,
    localparam int ID_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
    localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_CH-1:0]        up_req_valid,
    output logic [NUM_CH-1:0]        up_req_ready,
    input  logic [NUM_CH*DATA_W-1:0] up_req_data,
    input  logic [NUM_CH*PRIO_W-1:0] up_req_prio,
    input  logic [NUM_CH-1:0]        up_req_lock,
    output logic                     dn_req_valid,
    input  logic                     dn_req_ready,
    output logic [DATA_W-1:0]        dn_req_data,
    output logic [ID_W-1:0]          dn_req_id,
    input  logic                     dn_rsp_valid,
    output logic                     dn_rsp_ready,
    input  logic [DATA_W-1:0]        dn_rsp_data,
    output logic [NUM_CH-1:0]        up_rsp_valid,
    input  logic [NUM_CH-1:0]        up_rsp_ready,
    output logic [DATA_W-1:0]        up_rsp_data,
    output logic [CNT_W-1:0]         outstanding,
    output logic                     locked
);

    localparam int AW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;

    logic              can_accept;
    logic              any_win;
    logic              accept;
    logic              pop;
    logic              empty;
    logic [ID_W-1:0]   win;
    logic [ID_W-1:0]   head;
    logic [ID_W-1:0]   rr_ptr;
    logic [ID_W-1:0]   owner;
    logic [PRIO_W-1:0] best;
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [ID_W-1:0]   fifo [MAX_OUTSTANDING];

    assign empty      = (outstanding == '0);
    assign can_accept = (!dn_req_valid || dn_req_ready)
                      && (outstanding < CNT_W'(MAX_OUTSTANDING));
    assign accept     = can_accept && any_win;
    assign head       = fifo[rd_ptr];

    // Scan from rr_ptr; strict '>' keeps the first channel among equal priorities.
    always_comb begin
        int ch;
        logic elig;
        any_win = 1'b0;
        win     = '0;
        best    = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            ch   = (int'(rr_ptr) + i) % NUM_CH;
            elig = !locked || (ID_W'(ch) == owner);
            if (up_req_valid[ch] && elig &&
                (!any_win || up_req_prio[ch*PRIO_W +: PRIO_W] > best)) begin
                any_win = 1'b1;
                win     = ID_W'(ch);
                best    = up_req_prio[ch*PRIO_W +: PRIO_W];
            end
        end
    end

    assign up_req_ready = accept ? (NUM_CH'(1) << win) : '0;

    always_comb begin
        up_rsp_valid = '0;
        dn_rsp_ready = 1'b0;
        if (!empty) begin
            up_rsp_valid[head] = dn_rsp_valid;
            dn_rsp_ready       = up_rsp_ready[head];
        end
    end

    assign pop         = dn_rsp_valid && dn_rsp_ready;
    assign up_rsp_data = dn_rsp_data;

    always_ff @(posedge clk) begin
        if (rst) begin
            dn_req_valid <= 1'b0;
            dn_req_data  <= '0;
            dn_req_id    <= '0;
            rr_ptr       <= '0;
            locked       <= 1'b0;
            owner        <= '0;
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            outstanding  <= '0;
        end else begin
            if (accept) begin
                dn_req_valid <= 1'b1;
                dn_req_data  <= up_req_data[win*DATA_W +: DATA_W];
                dn_req_id    <= win;
                fifo[wr_ptr] <= win;
                wr_ptr       <= wr_ptr + AW'(1);
                rr_ptr       <= (int'(win) == NUM_CH - 1) ? '0 : win + ID_W'(1);
                locked       <= up_req_lock[win];
                if (up_req_lock[win]) begin
                    owner <= win;
                end
            end else if (dn_req_ready) begin
                dn_req_valid <= 1'b0;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({accept, pop})
                2'b10:   outstanding <= outstanding + CNT_W'(1);
                2'b01:   outstanding <= outstanding - CNT_W'(1);
                default: outstanding <= outstanding;
            endcase
        end
    end

endmodule

// File: tb/tb_nice_chain_arbiter.sv
// Directed bench for nice_chain_arbiter: arbitration order, priority,
// lock, backpressure, outstanding limit and response routing.
module tb_nice_chain_arbiter;

    logic         clk = 1'b0;
    logic         rst;
    logic [3:0]   up_req_valid;
    logic [3:0]   up_req_ready;
    logic [127:0] up_req_data;
    logic [7:0]   up_req_prio;
    logic [3:0]   up_req_lock;
    logic         dn_req_valid;
    logic         dn_req_ready;
    logic [31:0]  dn_req_data;
    logic [1:0]   dn_req_id;
    logic         dn_rsp_valid;
    logic         dn_rsp_ready;
    logic [31:0]  dn_rsp_data;
    logic [3:0]   up_rsp_valid;
    logic [3:0]   up_rsp_ready;
    logic [31:0]  up_rsp_data;
    logic [3:0]   outstanding;
    logic         locked;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    nice_chain_arbiter dut (
        .clk(clk), .rst(rst),
        .up_req_valid(up_req_valid), .up_req_ready(up_req_ready),
        .up_req_data(up_req_data), .up_req_prio(up_req_prio),
        .up_req_lock(up_req_lock),
        .dn_req_valid(dn_req_valid), .dn_req_ready(dn_req_ready),
        .dn_req_data(dn_req_data), .dn_req_id(dn_req_id),
        .dn_rsp_valid(dn_rsp_valid), .dn_rsp_ready(dn_rsp_ready),
        .dn_rsp_data(dn_rsp_data),
        .up_rsp_valid(up_rsp_valid), .up_rsp_ready(up_rsp_ready),
        .up_rsp_data(up_rsp_data),
        .outstanding(outstanding), .locked(locked)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst          = 1'b1;
        up_req_valid = '0;
        up_req_lock  = '0;
        up_req_prio  = '0;
        dn_req_ready = 1'b1;
        dn_rsp_valid = 1'b0;
        dn_rsp_data  = '0;
        up_rsp_ready = '0;
        for (int c = 0; c < 4; c++) up_req_data[c*32 +: 32] = 32'hA0 + c;
        step();
        step();
        rst = 1'b0;
        #1;
    endtask

    initial begin
        do_reset();
        chk("rst_dn_valid", dn_req_valid, 0);
        chk("rst_out", outstanding, 0);
        chk("rst_locked", locked, 0);
        chk("rst_ready", up_req_ready, 0);

        // round robin among equal priority
        up_req_valid = 4'hF;
        #1;
        for (int k = 0; k < 5; k++) begin
            chk("rr_ready", up_req_ready, 32'(1) << (k % 4));
            step();
            chk("rr_id", dn_req_id, k % 4);
            chk("rr_data", dn_req_data, 32'hA0 + (k % 4));
        end
        chk("rr_out", outstanding, 5);

        // priority: ch1 starves ch2
        do_reset();
        up_req_valid = 4'b0110;
        up_req_prio  = 8'b00_01_11_00;
        #1;
        for (int k = 0; k < 4; k++) begin
            chk("prio_ready", up_req_ready, 4'b0010);
            step();
            chk("prio_id", dn_req_id, 1);
        end
        up_req_valid = 4'b0100;
        #1;
        chk("prio_ch2", up_req_ready, 4'b0100);

        // lock held by ch2 blocks high-priority ch0
        do_reset();
        up_req_valid = 4'b0100;
        up_req_lock  = 4'b0100;
        #1;
        chk("lk_ready", up_req_ready, 4'b0100);
        step();
        chk("lk_locked", locked, 1);
        up_req_valid = 4'b0001;
        up_req_lock  = '0;
        up_req_prio  = 8'b00_00_00_11;
        #1;
        for (int k = 0; k < 3; k++) begin
            chk("lk_block", up_req_ready, 0);
            step();
        end
        up_req_valid = 4'b0101;
        #1;
        chk("lk_owner", up_req_ready, 4'b0100);
        step();
        chk("lk_release", locked, 0);
        chk("lk_id", dn_req_id, 2);
        up_req_valid = 4'b0001;
        #1;
        chk("lk_after", up_req_ready, 4'b0001);

        // downstream backpressure holds output register
        do_reset();
        dn_req_ready = 1'b0;
        up_req_valid = 4'b0010;
        #1;
        chk("bp_first", up_req_ready, 4'b0010);
        step();
        up_req_data[32 +: 32] = 32'hDEAD;
        up_req_valid = 4'b1010;
        #1;
        for (int k = 0; k < 5; k++) begin
            chk("bp_ready", up_req_ready, 0);
            chk("bp_valid", dn_req_valid, 1);
            chk("bp_data", dn_req_data, 32'hA1);
            chk("bp_id", dn_req_id, 1);
            step();
        end
        dn_req_ready = 1'b1;
        #1;
        chk("bp_rel", up_req_ready, 4'b1000);
        step();
        chk("bp_id3", dn_req_id, 3);

        // outstanding limit
        do_reset();
        up_req_valid = 4'b0001;
        #1;
        for (int k = 0; k < 8; k++) step();
        chk("full_out", outstanding, 8);
        chk("full_ready", up_req_ready, 0);
        dn_rsp_valid = 1'b1;
        up_rsp_ready = 4'b0001;
        #1;
        chk("full_rsp_v", up_rsp_valid, 4'b0001);
        chk("full_rsp_r", dn_rsp_ready, 1);
        step();
        chk("full_pop", outstanding, 7);
        dn_rsp_valid = 1'b0;
        #1;
        chk("full_reopen", up_req_ready, 4'b0001);
        step();
        chk("full_again", outstanding, 8);

        // response routing and mid-run reset
        do_reset();
        dn_rsp_valid = 1'b1;
        dn_rsp_data  = 32'h5555;
        #1;
        chk("unsol_ready", dn_rsp_ready, 0);
        chk("unsol_valid", up_rsp_valid, 0);
        dn_rsp_valid = 1'b0;
        up_req_valid = 4'b1000;
        #1;
        chk("rt_g3", up_req_ready, 4'b1000);
        step();
        up_req_valid = 4'b0010;
        #1;
        chk("rt_g1", up_req_ready, 4'b0010);
        step();
        up_req_valid = '0;
        chk("rt_out", outstanding, 2);
        dn_rsp_valid = 1'b1;
        dn_rsp_data  = 32'hAAAA;
        up_rsp_ready = 4'b1000;
        #1;
        chk("rt_a_v", up_rsp_valid, 4'b1000);
        chk("rt_a_d", up_rsp_data, 32'hAAAA);
        chk("rt_a_r", dn_rsp_ready, 1);
        step();
        dn_rsp_data = 32'hBBBB;
        #1;
        for (int k = 0; k < 2; k++) begin
            chk("rt_b_v", up_rsp_valid, 4'b0010);
            chk("rt_b_r", dn_rsp_ready, 0);
            step();
        end
        chk("rt_b_out", outstanding, 1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        #1;
        chk("mid_out", outstanding, 0);
        chk("mid_dn_valid", dn_req_valid, 0);
        chk("mid_rsp_v", up_rsp_valid, 0);
        chk("mid_rsp_r", dn_rsp_ready, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
